// File: rtl/mux_scan_ctrl.sv
// Sequencer that steps a 4:1 mux through channels 0..3, dwells DWELL cycles on
// each and assembles the sampled mux output into a 4-bit word with a done pulse.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 1,
   parameter int unsigned CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   output logic [1:0] sel,
   input  logic       y_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] data_out
);

   localparam int unsigned DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_EFF - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           state, state_nx;
   logic [1:0]       ch, ch_nx;
   logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nx;
   logic [2:0]       shadow, shadow_nx;
   logic [3:0]       data_nx;
   logic             busy_nx, done_nx;
   logic             dwell_end;

   assign dwell_end = (dwell_cnt == LAST_CNT);
   // sel is the channel register itself, so it can never disagree with ch
   assign sel = ch;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ch        <= 2'd0;
         dwell_cnt <= '0;
         shadow    <= 3'd0;
         data_out  <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         ch        <= ch_nx;
         dwell_cnt <= dwell_cnt_nx;
         shadow    <= shadow_nx;
         data_out  <= data_nx;
         busy      <= busy_nx;
         done      <= done_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_SCAN;
         S_SCAN:  if (dwell_end && (ch == 2'd3)) state_nx = S_DONE;
         S_DONE:  state_nx = cont ? S_SCAN : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      ch_nx        = ch;
      dwell_cnt_nx = dwell_cnt;
      shadow_nx    = shadow;
      data_nx      = data_out;
      case (state)
         S_SCAN: begin
            if (dwell_end) begin
               dwell_cnt_nx = '0;
               case (ch)
                  2'd0: shadow_nx[0] = y_in;
                  2'd1: shadow_nx[1] = y_in;
                  2'd2: shadow_nx[2] = y_in;
                  default: data_nx = {y_in, shadow};
               endcase
               ch_nx = ch + 2'd1;
            end else begin
               dwell_cnt_nx = dwell_cnt + CNT_W'(1);
            end
         end
         default: begin
            ch_nx        = 2'd0;
            dwell_cnt_nx = '0;
         end
      endcase
      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_DONE);
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (DWELL=1 and DWELL=3), each
// closing the loop through a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_a_n, start_a, cont_a, y_a, busy_a, done_a;
   logic [1:0] sel_a;
   logic [3:0] data_a, in_a;
   logic       rst_b_n, start_b, cont_b, y_b, busy_b, done_b;
   logic [1:0] sel_b;
   logic [3:0] data_b, in_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign y_a = in_a[sel_a];
   assign y_b = in_b[sel_b];

   mux_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .start(start_a), .cont(cont_a), .sel(sel_a),
      .y_in(y_a), .busy(busy_a), .done(done_a), .data_out(data_a)
   );

   mux_scan_ctrl #(.DWELL(3), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .start(start_b), .cont(cont_b), .sel(sel_b),
      .y_in(y_b), .busy(busy_b), .done(done_b), .data_out(data_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial begin
      int ndone;
      rst_a_n = 1'b0; start_a = 1'b0; cont_a = 1'b0; in_a = 4'd0;
      rst_b_n = 1'b0; start_b = 1'b0; cont_b = 1'b0; in_b = 4'd0;

      // Reset held 2 cycles with start asserted
      start_a = 1'b1; start_b = 1'b1;
      tick; tick;
      chk("rst_sel",  8'(sel_a),  8'd0);
      chk("rst_busy", 8'(busy_a), 8'd0);
      chk("rst_done", 8'(done_a), 8'd0);
      chk("rst_data", 8'(data_a), 8'd0);
      chk("rst_busy_b", 8'(busy_b), 8'd0);
      start_a = 1'b0; start_b = 1'b0;
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      tick;
      chk("idle_after_rst", 8'(busy_a), 8'd0);

      // One-shot, DWELL=1, In=1010
      in_a = 4'b1010;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("os_sel",  8'(sel_a),  8'(k));
         chk("os_busy", 8'(busy_a), 8'd1);
         chk("os_done", 8'(done_a), 8'd0);
         tick;
      end
      chk("os_done_t5", 8'(done_a), 8'd1);
      chk("os_data_t5", 8'(data_a), 8'b1010);
      chk("os_sel_t5",  8'(sel_a),  8'd0);
      tick;
      chk("os_done_t6", 8'(done_a), 8'd0);
      chk("os_busy_t6", 8'(busy_a), 8'd0);
      chk("os_data_t6", 8'(data_a), 8'b1010);

      // DWELL=3, In=0110, glitch on In[0] early in channel-0 dwell
      in_b = 4'b0110;
      start_b = 1'b1;
      tick;
      start_b = 1'b0;
      in_b[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c == 3) in_b[0] = 1'b0;
         chk("d3_sel", 8'(sel_b), 8'((c - 1) / 3));
         if (c == 12) chk("d3_done_early", 8'(done_b), 8'd0);
         tick;
      end
      chk("d3_done", 8'(done_b), 8'd1);
      chk("d3_data", 8'(data_b), 8'b0110);
      tick;
      chk("d3_idle", 8'(busy_b), 8'd0);

      // Continuous mode, DWELL=1
      cont_a = 1'b1;
      in_a = 4'b0001;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      tick; tick; tick;
      tick;
      chk("ct_done1", 8'(done_a), 8'd1);
      chk("ct_data1", 8'(data_a), 8'b0001);
      in_a = 4'b1000;
      tick;
      chk("ct_done_t6", 8'(done_a), 8'd0);
      chk("ct_busy_t6", 8'(busy_a), 8'd1);
      chk("ct_sel_t6",  8'(sel_a),  8'd0);
      tick;
      cont_a = 1'b0;
      chk("ct_sel_t7", 8'(sel_a), 8'd1);
      tick; tick;
      chk("ct_sel_t9",  8'(sel_a),  8'd3);
      chk("ct_data_t9", 8'(data_a), 8'b0001);
      tick;
      chk("ct_done2", 8'(done_a), 8'd1);
      chk("ct_data2", 8'(data_a), 8'b1000);
      tick;
      chk("ct_idle_busy", 8'(busy_a), 8'd0);
      chk("ct_idle_done", 8'(done_a), 8'd0);

      // start held high through a whole scan
      in_a = 4'b0101;
      start_a = 1'b1;
      tick;
      ndone = 0;
      for (int c = 1; c <= 5; c++) begin
         ndone += int'(done_a);
         tick;
      end
      chk("sh_idle_busy", 8'(busy_a), 8'd0);
      ndone += int'(done_a);
      chk("sh_one_done", 8'(ndone), 8'd1);
      tick;
      chk("sh_rescan_busy", 8'(busy_a), 8'd1);
      chk("sh_rescan_sel",  8'(sel_a),  8'd0);
      start_a = 1'b0;
      tick; tick; tick;
      tick;
      chk("sh_done2", 8'(done_a), 8'd1);
      chk("sh_data2", 8'(data_a), 8'b0101);
      tick;

      // Reset in the middle of a scan
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      tick; tick;
      chk("mr_sel_pre", 8'(sel_a), 8'd2);
      rst_a_n = 1'b0;
      tick;
      chk("mr_sel",  8'(sel_a),  8'd0);
      chk("mr_busy", 8'(busy_a), 8'd0);
      chk("mr_data", 8'(data_a), 8'd0);
      chk("mr_done", 8'(done_a), 8'd0);
      rst_a_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         tick;
         ndone += int'(done_a);
      end
      chk("mr_no_done", 8'(ndone), 8'd0);
      chk("mr_idle",    8'(busy_a), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
